// File: rtl/hamming_memory_scrubber.sv
// Background Hamming scrubber: sweeps every memory word, counts faulty blocks and the last faulty address.
// Corrected write-back is enabled by defining HAMMING_MEMORY_SCRUBBER_WRITEBACK_EN; otherwise report-only.
module hamming_memory_scrubber #(
  parameter int unsigned BLOCK_WIDTH = 15,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned COUNT_WIDTH = 8,
  localparam int unsigned ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     memory_grant,
  output logic                     memory_read_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_read_address,
  input  logic [BLOCK_WIDTH-1:0]   memory_read_data,
  output logic                     memory_write_enable,
  output logic [ADDRESS_WIDTH-1:0] memory_write_address,
  output logic [BLOCK_WIDTH-1:0]   memory_write_data,
  output logic [COUNT_WIDTH-1:0]   error_count,
  output logic [ADDRESS_WIDTH-1:0] last_error_address
);
  localparam int unsigned PARITY_WIDTH = $clog2(BLOCK_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, DONE} state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] address, address_next, last_error_next;
  logic [COUNT_WIDTH-1:0]   count_next;
  logic [PARITY_WIDTH-1:0]  syndrome;
  logic                     at_last_address;

  // Syndrome is the XOR of the 1-based positions of all set bits.
  function automatic logic [PARITY_WIDTH-1:0] syndrome_of(input logic [BLOCK_WIDTH-1:0] block);
    logic [PARITY_WIDTH-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
      if (block[i]) s = s ^ PARITY_WIDTH'(i + 1);
    end
    return s;
  endfunction

  // Syndromes beyond the block width match no position and leave the block untouched.
  function automatic logic [BLOCK_WIDTH-1:0] correct_block(input logic [BLOCK_WIDTH-1:0] block,
                                                          input logic [PARITY_WIDTH-1:0] syn);
    logic [BLOCK_WIDTH-1:0] r;
    r = block;
    for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
      if (PARITY_WIDTH'(i + 1) == syn) r[i] = ~r[i];
    end
    return r;
  endfunction

  // Parity bits live at power-of-two positions; recompute them from the data positions.
  function automatic logic [BLOCK_WIDTH-1:0] encode_block(input logic [BLOCK_WIDTH-1:0] block);
    logic [BLOCK_WIDTH-1:0]  r;
    logic [PARITY_WIDTH-1:0] s;
    r = block;
    for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
      if (((i + 1) & i) == 0) r[i] = 1'b0;
    end
    s = syndrome_of(r);
    for (int unsigned i = 0; i < BLOCK_WIDTH; i++) begin
      if (((i + 1) & i) == 0) r[i] = ^(PARITY_WIDTH'(i + 1) & s);
    end
    return r;
  endfunction

  assign syndrome        = syndrome_of(memory_read_data);
  assign at_last_address = (address == ADDRESS_WIDTH'(DEPTH - 1));

`ifdef HAMMING_MEMORY_SCRUBBER_WRITEBACK_EN
  logic [BLOCK_WIDTH-1:0] write_data_next;
  logic [BLOCK_WIDTH-1:0] reencoded;
  assign reencoded = encode_block(correct_block(memory_read_data, syndrome));
`endif

  always_comb begin
    state_next      = state;
    address_next    = address;
    count_next      = error_count;
    last_error_next = last_error_address;
`ifdef HAMMING_MEMORY_SCRUBBER_WRITEBACK_EN
    write_data_next = memory_write_data;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          address_next = '0;
          count_next   = '0;
          state_next   = READ;
        end
      end
      READ: begin
        if (memory_grant) state_next = CHECK;
      end
      CHECK: begin
        if (syndrome != '0) begin
          count_next      = (error_count == '1) ? error_count : error_count + COUNT_WIDTH'(1);
          last_error_next = address;
        end
`ifdef HAMMING_MEMORY_SCRUBBER_WRITEBACK_EN
        if (syndrome != '0) begin
          write_data_next = reencoded;
          state_next      = WRITE;
        end else if (at_last_address) begin
          state_next = DONE;
        end else begin
          address_next = address + ADDRESS_WIDTH'(1);
          state_next   = READ;
        end
`else
        if (at_last_address) begin
          state_next = DONE;
        end else begin
          address_next = address + ADDRESS_WIDTH'(1);
          state_next   = READ;
        end
`endif
      end
      WRITE: begin
        if (memory_grant) begin
          if (at_last_address) begin
            state_next = DONE;
          end else begin
            address_next = address + ADDRESS_WIDTH'(1);
            state_next   = READ;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request outputs are registered decodes of the next state, so grant never reaches them combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      address             <= '0;
      error_count         <= '0;
      last_error_address  <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      memory_read_enable  <= 1'b0;
      memory_read_address <= '0;
    end else begin
      state               <= state_next;
      address             <= address_next;
      error_count         <= count_next;
      last_error_address  <= last_error_next;
      busy                <= (state_next != IDLE);
      done                <= (state_next == DONE);
      memory_read_enable  <= (state_next == READ);
      memory_read_address <= (state_next == READ) ? address_next : '0;
    end
  end

`ifdef HAMMING_MEMORY_SCRUBBER_WRITEBACK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memory_write_enable  <= 1'b0;
      memory_write_address <= '0;
      memory_write_data    <= '0;
    end else begin
      memory_write_enable  <= (state_next == WRITE);
      memory_write_address <= (state_next == WRITE) ? address_next : '0;
      memory_write_data    <= write_data_next;
    end
  end
`else
  assign memory_write_enable  = 1'b0;
  assign memory_write_address = '0;
  assign memory_write_data    = '0;
`endif

endmodule

// File: tb/tb_hamming_memory_scrubber.sv
// Randomized bench for hamming_memory_scrubber: a word-level memory model and a sweep-level reference
// (expected reads, writes, counts, memory image and latency) derived from data-to-codeword encoding.
module tb_hamming_memory_scrubber;
  localparam int unsigned BW    = 15;
  localparam int unsigned DW    = 11;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 2;
  localparam int unsigned AW    = 4;
  localparam int          SAT   = (1 << CW) - 1;
`ifdef HAMMING_MEMORY_SCRUBBER_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy, done;
  logic          memory_grant = 1'b1;
  logic          memory_read_enable;
  logic [AW-1:0] memory_read_address;
  logic [BW-1:0] memory_read_data = '0;
  logic          memory_write_enable;
  logic [AW-1:0] memory_write_address;
  logic [BW-1:0] memory_write_data;
  logic [CW-1:0] error_count;
  logic [AW-1:0] last_error_address;

  hamming_memory_scrubber #(.BLOCK_WIDTH(BW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .memory_grant(memory_grant),
    .memory_read_enable(memory_read_enable), .memory_read_address(memory_read_address),
    .memory_read_data(memory_read_data),
    .memory_write_enable(memory_write_enable), .memory_write_address(memory_write_address),
    .memory_write_data(memory_write_data),
    .error_count(error_count), .last_error_address(last_error_address)
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            failures = 0;
  logic [BW-1:0] golden [DEPTH];
  logic [BW-1:0] image [DEPTH];
  logic [BW-1:0] mem [DEPTH];
  int            fault_bit [DEPTH];
  logic          load = 1'b0;
  int            grant_mode = 0;
  logic [AW-1:0] rd_q [$];
  logic [AW-1:0] wa_q [$];
  logic [BW-1:0] wd_q [$];
  int            done_count = 0;
  int            access_count = 0;
  int            hold_violations = 0;
  logic          hold_pending = 1'b0;
  logic          hold_re = 1'b0, hold_we = 1'b0;
  logic [AW-1:0] hold_ra = '0, hold_wa = '0;
  logic [AW-1:0] exp_last = '0;

  // Grant pattern: 0 = always granted, 1 = alternating, 2 = random.
  always @(negedge clock) begin
    case (grant_mode)
      1:       memory_grant <= ~memory_grant;
      2:       memory_grant <= 1'($urandom_range(0, 1));
      default: memory_grant <= 1'b1;
    endcase
  end

  // Memory with one-cycle read latency plus an access logger.
  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= image[i];
      rd_q.delete();
      wa_q.delete();
      wd_q.delete();
      done_count      <= 0;
      hold_violations <= 0;
      hold_pending    <= 1'b0;
    end else if (reset) begin
      hold_pending <= 1'b0;
    end else begin
      if (memory_read_enable && memory_grant) begin
        rd_q.push_back(memory_read_address);
        memory_read_data <= mem[memory_read_address];
      end
      if (memory_write_enable && memory_grant) begin
        wa_q.push_back(memory_write_address);
        wd_q.push_back(memory_write_data);
        mem[memory_write_address] <= memory_write_data;
      end
      if (done) done_count <= done_count + 1;
      if (memory_read_enable || memory_write_enable) access_count <= access_count + 1;
      if (hold_pending && (memory_read_enable !== hold_re || memory_write_enable !== hold_we ||
                           memory_read_address !== hold_ra || memory_write_address !== hold_wa))
        hold_violations <= hold_violations + 1;
      hold_pending <= (memory_read_enable || memory_write_enable) && !memory_grant;
      hold_re      <= memory_read_enable;
      hold_we      <= memory_write_enable;
      hold_ra      <= memory_read_address;
      hold_wa      <= memory_write_address;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, expected);
    end
  endtask

  // Data bits fill the non-power-of-two positions in order; parity k covers positions with bit k set.
  function automatic logic [BW-1:0] encode_data(input logic [DW-1:0] d);
    logic [BW-1:0] b;
    int            j;
    logic          p;
    b = '0;
    j = 0;
    for (int pos = 1; pos <= BW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        b[pos-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= BW; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ b[pos-1];
      b[(1 << k) - 1] = p;
    end
    return b;
  endfunction

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) fault_bit[a] = -1;
  endtask

  task automatic prepare();
    for (int a = 0; a < DEPTH; a++) begin
      golden[a] = encode_data(DW'($urandom));
      image[a]  = golden[a];
      if (fault_bit[a] >= 0) image[a][fault_bit[a]] = ~image[a][fault_bit[a]];
    end
  endtask

  task automatic load_memory();
    @(negedge clock);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic run_sweep(input int mode, input bit restart_mid, output int cycles);
    grant_mode = mode;
    load_memory();
    @(negedge clock);
    start  = 1'b1;
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
      start = restart_mid && (cycles == 10);
    end while (!done && cycles < 400);
    start = 1'b0;
    check("done_seen", done, 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic verify_sweep(input string name, input int cycles, input bit timed);
    int n = 0;
    int last = -1;
    int bad_words = 0;
    int exp_wa [$];
    for (int a = 0; a < DEPTH; a++) begin
      if (fault_bit[a] >= 0) begin
        n++;
        last = a;
        if (WB) exp_wa.push_back(a);
      end
    end
    if (n > 0) exp_last = AW'(last);
    check($sformatf("%s_busy_after", name), busy, 0);
    check($sformatf("%s_done_pulses", name), done_count, 1);
    check($sformatf("%s_request_hold", name), hold_violations, 0);
    check($sformatf("%s_read_count", name), rd_q.size(), DEPTH);
    for (int i = 0; i < rd_q.size() && i < DEPTH; i++)
      check($sformatf("%s_read_addr%0d", name, i), rd_q[i], i);
    check($sformatf("%s_write_count", name), wa_q.size(), exp_wa.size());
    for (int i = 0; i < wa_q.size() && i < exp_wa.size(); i++) begin
      check($sformatf("%s_write_addr%0d", name, i), wa_q[i], exp_wa[i]);
      check($sformatf("%s_write_data%0d", name, i), wd_q[i], golden[exp_wa[i]]);
    end
    check($sformatf("%s_error_count", name), error_count, (n < SAT) ? n : SAT);
    check($sformatf("%s_last_error", name), last_error_address, exp_last);
    for (int a = 0; a < DEPTH; a++)
      if (mem[a] !== (WB ? golden[a] : image[a])) bad_words++;
    check($sformatf("%s_memory_image", name), bad_words, 0);
    if (timed)
      check($sformatf("%s_latency", name), cycles, 2 * DEPTH + 1 + (WB ? n : 0));
  endtask

  task automatic check_all_zero(input string name);
    check($sformatf("%s_busy", name), busy, 0);
    check($sformatf("%s_done", name), done, 0);
    check($sformatf("%s_rd_en", name), memory_read_enable, 0);
    check($sformatf("%s_rd_addr", name), memory_read_address, 0);
    check($sformatf("%s_wr_en", name), memory_write_enable, 0);
    check($sformatf("%s_wr_addr", name), memory_write_address, 0);
    check($sformatf("%s_wr_data", name), memory_write_data, 0);
    check($sformatf("%s_err_count", name), error_count, 0);
    check($sformatf("%s_last_err", name), last_error_address, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int waited;
    int snapshot;
    reset = 1'b0;
    start = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    clear_faults();
    prepare();
    run_sweep(0, 1'b0, cyc);
    verify_sweep("clean", cyc, 1'b1);

    clear_faults();
    fault_bit[5] = 4;
    prepare();
    run_sweep(0, 1'b0, cyc);
    verify_sweep("addr5_bit4", cyc, 1'b1);

    clear_faults();
    fault_bit[0]  = $urandom_range(0, BW - 1);
    fault_bit[15] = $urandom_range(0, BW - 1);
    prepare();
    run_sweep(1, 1'b0, cyc);
    verify_sweep("ends_toggle", cyc, 1'b0);

    for (int a = 0; a < DEPTH; a++) fault_bit[a] = $urandom_range(0, BW - 1);
    prepare();
    run_sweep(2, 1'b0, cyc);
    verify_sweep("all_faulty", cyc, 1'b0);

    // Abort a sweep while it is working on address 7.
    clear_faults();
    fault_bit[2] = $urandom_range(0, BW - 1);
    fault_bit[7] = $urandom_range(0, BW - 1);
    prepare();
    grant_mode = 0;
    load_memory();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    waited = 0;
    while (!(WB ? (memory_write_enable && memory_write_address == 4'd7)
                : (memory_read_enable && memory_read_address == 4'd7)) && waited < 200) begin
      @(posedge clock);
      #1;
      waited++;
    end
    check("abort_target_reached", waited < 200, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("abort");
    snapshot = access_count;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    exp_last = '0;
    repeat (6) @(posedge clock);
    #1;
    check("abort_no_access", access_count, snapshot);
    check("abort_idle", busy, 0);

    clear_faults();
    for (int k = 0; k < 4; k++) fault_bit[$urandom_range(0, DEPTH - 1)] = $urandom_range(0, BW - 1);
    prepare();
    run_sweep(2, 1'b0, cyc);
    verify_sweep("after_abort", cyc, 1'b0);

    clear_faults();
    for (int k = 0; k < 3; k++) fault_bit[$urandom_range(0, DEPTH - 1)] = $urandom_range(0, BW - 1);
    prepare();
    run_sweep(0, 1'b1, cyc);
    verify_sweep("restart_ignored", cyc, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
